tone_key_controller: RTL and testbench
======================================

# tone_key_controller

Arbitrates four held note keys onto the single square-wave tone channel. Selects one key, programs the shared frequency divider with that note's half-period, and holds the divider in reset while silent. Toggles the audio output on each divider tick. Inserts a short silent gap between notes so note changes are audible and click-free. Sits between the key synchronisers and the audio DAC/pin driver.

## Interface
- NUM_KEYS, 4, number of key requesters; fixed at 4 for this revision.
- GAP_CYCLES, 1000, silent clock cycles between notes; must be ≥1.
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- enable  in  1  master enable; low forces silence.
- key  in  NUM_KEYS  held-key requests, active-high, already synchronised.
- tick  in  1  one-cycle pulse from the divider, period = half-period of the current note.
- div_count_up_to  out  32  terminal count for the divider.
- div_reset  out  1  holds the divider counter at 0.
- audio_out  out  1  square-wave tone.
- playing  out  1  high while in PLAY.
- active_key  out  2  index of the key currently owning the channel.

## Operation
- Reset values: state IDLE, div_reset=1, div_count_up_to=0, audio_out=0, playing=0, active_key=0, gap counter=0.
- Divider contract: a count_up_to of N gives one tick every N+1 cycles. Programmed value = NOTE_HALF_PERIOD[k] − 1.
- Selection is fixed-priority: the lowest-index asserted key wins. There is no preemption; the owning key plays until it is released.
- States:
  - IDLE: div_reset=1, audio_out=0. If enable and any key is asserted, latch the winner into active_key, load div_count_up_to, go to RESTART.
  - RESTART: exactly one cycle. div_reset=1, audio_out=0. Next state is PLAY.
  - PLAY: div_reset=0, playing=1. Each tick toggles audio_out. If key[active_key] is low, go to GAP and load the gap counter with GAP_CYCLES−1.
  - GAP: div_reset=1, audio_out=0, counter decrements each cycle. Keys are ignored until the counter reaches 0.
    - At 0 with any key asserted: re-arbitrate, load, go to RESTART.
    - At 0 with no key asserted: go to IDLE.
- Simultaneous events:
  - Release and tick in the same cycle: release wins; audio_out goes to 0, not toggled.
  - Higher-priority key pressed during PLAY: ignored.
- enable low in any state: next state is IDLE and all outputs go to their reset values, except div_count_up_to, which holds.
- tick outside PLAY: ignored.
- Reset mid-note: returns to IDLE in one cycle; audio_out is 0 on the following cycle.
- Width rule: table entries fit in 32 bits; the subtract-1 never underflows because every entry is ≥2.

## Timing
- All outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.
- Key sampled high at edge t (in IDLE) → RESTART during t..t+1 → PLAY from edge t+1.
- div_count_up_to is valid from edge t, at least one cycle before div_reset deasserts.
- Tick sampled at edge e → audio_out toggles at edge e (visible the following cycle).
- Release sampled at edge r → audio_out=0 and div_reset=1 from edge r.
- Minimum silence between notes = GAP_CYCLES + 1 cycles (gap plus RESTART).

## Structure
- Shared package synth_pkg holds:
  - NOTE_HALF_PERIOD[0:3] at 50 MHz: C4 95556, E4 75843, G4 63776, C5 47778.
  - The state enum (IDLE, RESTART, PLAY, GAP).
  - The key index width.
- Sub-module key_priority_select: combinational lowest-index-first picker producing a valid flag and an index. It is the natural split because a later polyphonic revision reuses it.
- Main module holds the FSM, gap counter, output registers and table lookup.

## Test plan
- Reset held 3 cycles with key=4'b1111 → div_reset=1, audio_out=0, playing=0, active_key=0 throughout.
- key=4'b0100 in IDLE → one RESTART cycle, then playing=1, active_key=2, div_count_up_to=63775. Bench ticks every 10 cycles → audio_out toggles on each tick.
- key=4'b0110 → active_key=1. Drop key[2] → no change. Drop key[1] → GAP; with GAP_CYCLES=4 → 4 silent cycles, then RESTART with active_key=2.
- Release and tick in the same cycle → audio_out=0 next cycle with no toggle. All keys released → GAP then IDLE.
- Key pressed and released entirely within GAP → ignored; controller ends in IDLE.
- enable or reset dropped mid-PLAY with audio_out=1 → audio_out=0 and div_reset=1 on the next cycle; re-enable with key held → a new RESTART/PLAY sequence.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and types for the tone channel: note table, FSM states,
// and the key index width used by the arbiter and the controller.
package synth_pkg;

  localparam int NUM_NOTES = 4;
  localparam int KEY_IDX_W = 2;
  localparam int DIV_W     = 32;

  // Half-periods at 50 MHz: C4, E4, G4, C5.
  localparam logic [DIV_W-1:0] NOTE_HALF_PERIOD [0:NUM_NOTES-1] = '{
    32'd95556, 32'd75843, 32'd63776, 32'd47778
  };

  typedef enum logic [1:0] {
    IDLE,
    RESTART,
    PLAY,
    GAP
  } state_t;

  // The divider ticks every N+1 cycles, so program one less than the half-period.
  function automatic logic [DIV_W-1:0] note_count_up_to(input logic [KEY_IDX_W-1:0] idx);
    return NOTE_HALF_PERIOD[idx] - 32'd1;
  endfunction

endpackage

// File: rtl/key_priority_select.sv
// Combinational fixed-priority picker: the lowest-index asserted key wins.
module key_priority_select
  import synth_pkg::*;
#(
  parameter int NUM_KEYS = 4
) (
  input  logic [NUM_KEYS-1:0]  key,
  output logic                 valid,
  output logic [KEY_IDX_W-1:0] index
);

  always_comb begin
    valid = |key;
    index = '0;
    // NOTE: scanning downwards lets the lowest asserted index be the last
    // assignment; index gets a default first so no latch is inferred.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key[i]) index = KEY_IDX_W'(i);
    end
  end

endmodule

// File: rtl/tone_key_controller.sv
// Arbitrates held note keys onto one square-wave channel, programming the
// shared divider and inserting a silent gap between notes.
module tone_key_controller
  import synth_pkg::*;
#(
  parameter int NUM_KEYS   = 4,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_KEYS-1:0]  key,
  input  logic                 tick,
  output logic [DIV_W-1:0]     div_count_up_to,
  output logic                 div_reset,
  output logic                 audio_out,
  output logic                 playing,
  output logic [KEY_IDX_W-1:0] active_key
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  state_t               state, state_nxt;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_nxt;
  logic [DIV_W-1:0]     count_nxt;
  logic                 audio_nxt;
  logic [KEY_IDX_W-1:0] key_nxt;
  logic                 pick_valid;
  logic [KEY_IDX_W-1:0] pick_index;
  logic                 owner_held;

  key_priority_select #(.NUM_KEYS(NUM_KEYS)) u_select (
    .key   (key),
    .valid (pick_valid),
    .index (pick_index)
  );

  assign owner_held = key[active_key];

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    count_nxt   = div_count_up_to;
    audio_nxt   = audio_out;
    key_nxt     = active_key;

    if (!enable) begin
      // Master disable silences everything but leaves the divider value alone.
      state_nxt   = IDLE;
      gap_cnt_nxt = '0;
      audio_nxt   = 1'b0;
      key_nxt     = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            key_nxt   = pick_index;
            count_nxt = note_count_up_to(pick_index);
            state_nxt = RESTART;
          end
        end
        RESTART: state_nxt = PLAY;
        PLAY: begin
          // Release outranks a coincident tick so the note ends on silence.
          if (!owner_held) begin
            state_nxt   = GAP;
            gap_cnt_nxt = GAP_LOAD;
            audio_nxt   = 1'b0;
          end else if (tick) begin
            audio_nxt = ~audio_out;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (pick_valid) begin
              key_nxt   = pick_index;
              count_nxt = note_count_up_to(pick_index);
              state_nxt = RESTART;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            gap_cnt_nxt = gap_cnt - 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments under a synchronous active-high
  // reset, so reset is only honoured on a clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      gap_cnt         <= '0;
      div_count_up_to <= '0;
      audio_out       <= 1'b0;
      active_key      <= '0;
    end else begin
      state           <= state_nxt;
      gap_cnt         <= gap_cnt_nxt;
      div_count_up_to <= count_nxt;
      audio_out       <= audio_nxt;
      active_key      <= key_nxt;
    end
  end

  assign div_reset = (state != PLAY);
  assign playing   = (state == PLAY);

endmodule

// File: tb/tb_tone_key_controller.sv
// Scoreboard bench for tone_key_controller: a cycle-level note-timeline model
// predicts every output, a monitor compares on the falling edge.
module tb_tone_key_controller;

  localparam int GAP = 4;

  logic        clock = 1'b0;
  logic        reset, enable, tick;
  logic [3:0]  key;
  logic [31:0] div_count_up_to;
  logic        div_reset, audio_out, playing;
  logic [1:0]  active_key;

  always #10 clock = ~clock;

  tone_key_controller #(.NUM_KEYS(4), .GAP_CYCLES(GAP)) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .key             (key),
    .tick            (tick),
    .div_count_up_to (div_count_up_to),
    .div_reset       (div_reset),
    .audio_out       (audio_out),
    .playing         (playing),
    .active_key      (active_key)
  );

  typedef struct packed {
    logic [31:0] cut;
    logic        div_reset;
    logic        audio;
    logic        playing;
    logic [1:0]  act;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Note half-periods in clock cycles: C4, E4, G4, C5.
  int half_period [4] = '{95556, 75843, 63776, 47778};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  function automatic int lowest_key(input logic [3:0] k);
    for (int i = 0; i < 4; i++) if (k[i]) return i;
    return -1;
  endfunction

  // Reference model: a note is silent, arming (one cycle), sounding (audio is
  // the parity of ticks since it started) or in a gap that ends at a known edge.
  typedef enum {M_SILENT, M_ARMING, M_SOUNDING, M_GAPPING} mode_t;
  mode_t       m_mode = M_SILENT;
  int          m_act = 0, m_ticks = 0, m_edge = 0, m_gap_end = 0;
  logic [31:0] m_cut = 0;

  initial begin : model
    exp_t e;
    forever begin
      @(posedge clock);
      m_edge++;
      if (reset) begin
        m_mode = M_SILENT; m_act = 0; m_cut = 0; m_ticks = 0;
      end else if (!enable) begin
        m_mode = M_SILENT; m_act = 0; m_ticks = 0;
      end else begin
        case (m_mode)
          M_SILENT:
            if (lowest_key(key) >= 0) begin
              m_act = lowest_key(key); m_cut = half_period[m_act] - 1; m_mode = M_ARMING;
            end
          M_ARMING: begin m_mode = M_SOUNDING; m_ticks = 0; end
          M_SOUNDING:
            if (!key[m_act]) begin
              m_mode = M_GAPPING; m_ticks = 0; m_gap_end = m_edge + GAP;
            end else if (tick) begin
              m_ticks++;
            end
          M_GAPPING:
            if (m_edge >= m_gap_end) begin
              if (lowest_key(key) >= 0) begin
                m_act = lowest_key(key); m_cut = half_period[m_act] - 1; m_mode = M_ARMING;
              end else begin
                m_mode = M_SILENT;
              end
            end
          default: m_mode = M_SILENT;
        endcase
      end
      e.cut       = m_cut;
      e.div_reset = (m_mode != M_SOUNDING);
      e.playing   = (m_mode == M_SOUNDING);
      e.audio     = (m_mode == M_SOUNDING) && (m_ticks % 2 == 1);
      e.act       = 2'(m_act);
      sb.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("div_count_up_to", div_count_up_to, e.cut);
        check("div_reset", 32'(div_reset), 32'(e.div_reset));
        check("audio_out", 32'(audio_out), 32'(e.audio));
        check("playing", 32'(playing), 32'(e.playing));
        check("active_key", 32'(active_key), 32'(e.act));
      end
    end
  end

  task automatic cyc(input logic r, input logic en, input logic [3:0] k, input logic t);
    reset = r; enable = en; key = k; tick = t;
    @(posedge clock);
    #1;
  endtask

  task automatic run(input logic r, input logic en, input logic [3:0] k, input int n, input int tick_every);
    for (int i = 0; i < n; i++)
      cyc(r, en, k, (tick_every > 0) && ((i + 1) % tick_every == 0));
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b1; enable = 1'b1; key = 4'b1111; tick = 1'b0;
    run(1, 1, 4'b1111, 3, 0);
    run(0, 1, 4'b0000, 2, 0);

    // Single note G4 with a tick every 10 cycles, then release into gap and idle.
    run(0, 1, 4'b0100, 41, 10);
    run(0, 1, 4'b0000, 8, 0);

    // Priority and no preemption; dropping the owner re-arbitrates after the gap.
    run(0, 1, 4'b0110, 20, 10);
    run(0, 1, 4'b0010, 15, 10);
    run(0, 1, 4'b0110, 5, 0);
    run(0, 1, 4'b0100, 10, 0);

    // Release coinciding with a tick while audio is high.
    cyc(0, 1, 4'b0100, 1);
    run(0, 1, 4'b0100, 2, 0);
    cyc(0, 1, 4'b0000, 1);
    run(0, 1, 4'b0000, 8, 0);

    // A key pressed and released entirely inside the gap is ignored.
    run(0, 1, 4'b0001, 6, 0);
    cyc(0, 1, 4'b0001, 1);
    run(0, 1, 4'b0000, 1, 0);
    run(0, 1, 4'b1000, 2, 0);
    run(0, 1, 4'b0000, 8, 0);

    // Enable dropped mid-note with audio high, then re-enabled with key held.
    run(0, 1, 4'b0001, 4, 0);
    cyc(0, 1, 4'b0001, 1);
    run(0, 1, 4'b0001, 2, 0);
    run(0, 0, 4'b0001, 3, 0);
    run(0, 1, 4'b0001, 6, 3);

    // Reset mid-note with audio high, then recovery.
    run(0, 1, 4'b0000, 8, 0);
    run(0, 1, 4'b0001, 4, 0);
    cyc(0, 1, 4'b0001, 1);
    run(1, 1, 4'b0001, 1, 0);
    run(0, 1, 4'b0001, 6, 0);

    // Randomised phase: held key patterns, sparse enable/reset drops, random ticks.
    for (int it = 0; it < 300; it++) begin
      logic        r, en;
      logic [3:0]  k;
      int          n;
      r  = ($urandom % 60 == 0);
      en = ($urandom % 25 != 0);
      k  = ($urandom % 4 == 0) ? 4'b0000 : 4'($urandom);
      n  = $urandom_range(1, 25);
      for (int j = 0; j < n; j++) cyc(r, en, k, ($urandom % 4 == 0));
    end

    run(0, 1, 4'b0000, 10, 0);
    @(negedge clock);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
